// File: rtl/dkong3_obj_pkg.sv
// Shared definitions for the per-scanline object evaluator: object byte
// offsets, FSM state encoding and hit-record packing.
package dkong3_obj_pkg;

    localparam logic [1:0] OFS_Y    = 2'd0;
    localparam logic [1:0] OFS_CODE = 2'd1;
    localparam logic [1:0] OFS_ATTR = 2'd2;
    localparam logic [1:0] OFS_X    = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_Y = 3'd1,
        EVAL    = 3'd2,
        B1      = 3'd3,
        B2      = 3'd4,
        B3      = 3'd5,
        FIN     = 3'd6
    } obj_state_e;

    localparam int HIT_LINE_LSB = 0;
    localparam int HIT_CODE_LSB = 8;
    localparam int HIT_ATTR_LSB = 16;
    localparam int HIT_X_LSB    = 24;

    function automatic logic [31:0] pack_hit(
        input logic [7:0] x,
        input logic [7:0] attr,
        input logic [7:0] code,
        input logic [7:0] line
    );
        logic [31:0] rec;
        rec                      = 32'h0000_0000;
        rec[HIT_X_LSB    +: 8]   = x;
        rec[HIT_ATTR_LSB +: 8]   = attr;
        rec[HIT_CODE_LSB +: 8]   = code;
        rec[HIT_LINE_LSB +: 8]   = line;
        return rec;
    endfunction

endpackage

// File: rtl/dkong3_obj_ycmp.sv
// Wrap-around vertical compare: distance from sprite top to the target line,
// and whether that line falls inside the sprite.
module dkong3_obj_ycmp #(
    parameter int OBJ_H = 16
) (
    input  logic [7:0] line_i,
    input  logic [7:0] y_i,
    output logic       hit_o,
    output logic [7:0] d_o
);

    assign d_o   = line_i - y_i;
    assign hit_o = ({1'b0, d_o} < 9'(OBJ_H));

endmodule

// File: rtl/dkong3_obj_scan.sv
// Per-scanline sprite evaluator: walks object RAM, pushes intersecting
// sprites into the hit list and reports completion and overflow.
module dkong3_obj_scan #(
    parameter int         NUM_OBJ  = 96,
    parameter logic [9:0] OBJ_BASE = 10'h000,
    parameter int         MAX_HITS = 16,
    parameter logic [7:0] Y_OFS    = 8'h00,
    parameter int         OBJ_H    = 16
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_SCAN_START,
    input  logic [7:0]  I_VPOS,
    input  logic        I_HOLD,
    output logic [9:0]  O_OBJ_A,
    input  logic [7:0]  I_OBJ_D,
    output logic        O_HIT_WE,
    output logic [3:0]  O_HIT_IDX,
    output logic [31:0] O_HIT_D,
    output logic [4:0]  O_HIT_CNT,
    output logic        O_DONE,
    output logic        O_OVF
);

    import dkong3_obj_pkg::*;

    obj_state_e  state_q;
    logic        start_q;
    logic        hold_q;
    logic        pend_q;
    logic [7:0]  pvpos_q;
    logic [7:0]  cap_q;
    logic [7:0]  line_q;
    logic [7:0]  dist_q;
    logic [7:0]  code_q;
    logic [7:0]  attr_q;
    logic [6:0]  n_q;
    logic [9:0]  addr_q;
    logic        we_q;
    logic        done_q;
    logic        ovf_q;
    logic [3:0]  idx_q;
    logic [31:0] hit_d_q;
    logic [4:0]  cnt_q;

    logic        start_edge_s;
    logic [7:0]  obj_d_s;
    logic        ycmp_hit_s;
    logic [7:0]  ycmp_d_s;
    logic        last_s;
    logic        full_s;
    logic [6:0]  n_inc_s;
    logic [9:0]  entry_a_s;
    logic [9:0]  next_y_a_s;
    logic [7:0]  start_vpos_s;

    assign start_edge_s = I_SCAN_START & ~start_q;
    assign start_vpos_s = start_edge_s ? I_VPOS : pvpos_q;
    // The first cycle after a hold sees data read on the DMA's behalf, so
    // substitute the byte captured as the hold began.
    assign obj_d_s      = hold_q ? cap_q : I_OBJ_D;
    assign last_s       = (n_q == 7'(NUM_OBJ - 1));
    assign full_s       = (cnt_q == 5'(MAX_HITS));
    assign n_inc_s      = n_q + 7'd1;
    assign entry_a_s    = OBJ_BASE + {1'b0, n_q, 2'b00};
    assign next_y_a_s   = OBJ_BASE + {1'b0, n_inc_s, 2'b00} + {8'h00, OFS_Y};

    dkong3_obj_ycmp #(.OBJ_H(OBJ_H)) u_ycmp (
        .line_i (line_q),
        .y_i    (obj_d_s),
        .hit_o  (ycmp_hit_s),
        .d_o    (ycmp_d_s)
    );

    assign O_OBJ_A   = addr_q;
    assign O_HIT_WE  = we_q & ~I_HOLD;
    assign O_HIT_IDX = idx_q;
    assign O_HIT_D   = hit_d_q;
    assign O_HIT_CNT = cnt_q;
    assign O_DONE    = done_q & ~I_HOLD;
    assign O_OVF     = ovf_q;

    // Scan FSM; the address register always points one byte ahead of the
    // byte being consumed so each RAM read lands in the following state.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            hold_q  <= 1'b0;
            pend_q  <= 1'b0;
            pvpos_q <= 8'h00;
            cap_q   <= 8'h00;
            line_q  <= 8'h00;
            dist_q  <= 8'h00;
            code_q  <= 8'h00;
            attr_q  <= 8'h00;
            n_q     <= 7'd0;
            addr_q  <= 10'h000;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= 4'h0;
            hit_d_q <= 32'h0000_0000;
            cnt_q   <= 5'd0;
        end else begin
            start_q <= I_SCAN_START;
            hold_q  <= I_HOLD;
            if (I_HOLD && !hold_q) begin
                cap_q <= I_OBJ_D;
            end
            if (I_HOLD) begin
                if (start_edge_s) begin
                    pend_q  <= 1'b1;
                    pvpos_q <= I_VPOS;
                end
            end else if (start_edge_s || pend_q) begin
                pend_q  <= 1'b0;
                line_q  <= start_vpos_s + Y_OFS;
                n_q     <= 7'd0;
                cnt_q   <= 5'd0;
                ovf_q   <= 1'b0;
                we_q    <= 1'b0;
                done_q  <= 1'b0;
                addr_q  <= OBJ_BASE + {8'h00, OFS_Y};
                state_q <= FETCH_Y;
            end else begin
                we_q   <= 1'b0;
                done_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    FETCH_Y: begin
                        addr_q  <= entry_a_s + {8'h00, OFS_CODE};
                        state_q <= EVAL;
                    end
                    EVAL: begin
                        dist_q <= ycmp_d_s;
                        if (!ycmp_hit_s) begin
                            if (last_s) begin
                                state_q <= FIN;
                            end else begin
                                n_q     <= n_inc_s;
                                addr_q  <= next_y_a_s;
                                state_q <= FETCH_Y;
                            end
                        end else if (full_s) begin
                            ovf_q   <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            addr_q  <= entry_a_s + {8'h00, OFS_ATTR};
                            state_q <= B1;
                        end
                    end
                    B1: begin
                        code_q  <= obj_d_s;
                        addr_q  <= entry_a_s + {8'h00, OFS_X};
                        state_q <= B2;
                    end
                    B2: begin
                        attr_q  <= obj_d_s;
                        state_q <= B3;
                    end
                    B3: begin
                        we_q    <= 1'b1;
                        idx_q   <= cnt_q[3:0];
                        hit_d_q <= pack_hit(obj_d_s, attr_q, code_q, dist_q);
                        cnt_q   <= cnt_q + 5'd1;
                        if (last_s) begin
                            state_q <= FIN;
                        end else begin
                            n_q     <= n_inc_s;
                            addr_q  <= next_y_a_s;
                            state_q <= FETCH_Y;
                        end
                    end
                    FIN: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dkong3_obj_scan.sv
// Directed bench for dkong3_obj_scan: synchronous-read object RAM model that
// returns junk while held, plus per-scenario tasks with hand-computed results.
module tb_dkong3_obj_scan;

    logic        clk;
    logic        I_RST;
    logic        I_SCAN_START;
    logic [7:0]  I_VPOS;
    logic        I_HOLD;
    logic [9:0]  O_OBJ_A;
    logic [7:0]  I_OBJ_D;
    logic        O_HIT_WE;
    logic [3:0]  O_HIT_IDX;
    logic [31:0] O_HIT_D;
    logic [4:0]  O_HIT_CNT;
    logic        O_DONE;
    logic        O_OVF;

    dkong3_obj_scan dut (
        .I_CLK        (clk),
        .I_RST        (I_RST),
        .I_SCAN_START (I_SCAN_START),
        .I_VPOS       (I_VPOS),
        .I_HOLD       (I_HOLD),
        .O_OBJ_A      (O_OBJ_A),
        .I_OBJ_D      (I_OBJ_D),
        .O_HIT_WE     (O_HIT_WE),
        .O_HIT_IDX    (O_HIT_IDX),
        .O_HIT_D      (O_HIT_D),
        .O_HIT_CNT    (O_HIT_CNT),
        .O_DONE       (O_DONE),
        .O_OVF        (O_OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:1023];

    always @(posedge clk) begin
        I_OBJ_D <= I_HOLD ? 8'hA5 : ram[O_OBJ_A];
    end

    int          checks;
    int          failures;
    int          nwe;
    int          done_k;
    int          both_seen;
    logic [4:0]  cnt_snap;
    logic [3:0]  we_idx [0:31];
    logic [31:0] we_dat [0:31];
    int          we_k   [0:31];
    logic [4:0]  we_cnt [0:31];
    logic [4:0]  fin_cnt;
    logic        fin_ovf;

    task automatic fill_bg(input logic [7:0] y);
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        for (int n = 0; n < 96; n++) ram[4*n] = y;
    endtask

    task automatic set_obj(input int n, input logic [7:0] y, input logic [7:0] code,
                           input logic [7:0] attr, input logic [7:0] x);
        ram[4*n]   = y;
        ram[4*n+1] = code;
        ram[4*n+2] = attr;
        ram[4*n+3] = x;
    endtask

    task automatic do_start(input logic [7:0] vpos);
        @(negedge clk);
        I_VPOS       = vpos;
        I_SCAN_START = 1'b1;
        @(posedge clk);
        #1;
        I_SCAN_START = 1'b0;
    endtask

    // k counts clock edges after the accepting start edge; stops at O_DONE or limit
    task automatic run_scan(input logic [7:0] vpos, input int hold_at, input int hold_len,
                            input int restart_at, input logic [7:0] rvpos, input int limit);
        nwe = 0; done_k = -1; both_seen = 0; cnt_snap = 5'h1F;
        do_start(vpos);
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (O_HIT_WE && O_DONE) both_seen++;
            if (O_HIT_WE && nwe < 32) begin
                we_idx[nwe] = O_HIT_IDX; we_dat[nwe] = O_HIT_D;
                we_k[nwe] = k; we_cnt[nwe] = O_HIT_CNT; nwe++;
            end
            if (k == restart_at + 1) begin
                cnt_snap = O_HIT_CNT;
                I_SCAN_START = 1'b0;
            end
            if (O_DONE) begin
                done_k = k;
                break;
            end
            if (k == restart_at) begin
                I_VPOS = rvpos;
                I_SCAN_START = 1'b1;
            end
            if (k == hold_at) I_HOLD = 1'b1;
            if (k == hold_at + hold_len) I_HOLD = 1'b0;
        end
        fin_cnt = O_HIT_CNT;
        fin_ovf = O_OVF;
        I_HOLD = 1'b0;
        I_SCAN_START = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({O_OBJ_A, O_HIT_WE, O_HIT_IDX, O_HIT_D, O_HIT_CNT, O_DONE, O_OVF} !== 53'd0) begin
            failures++;
            $display("FAIL reset_outputs: got A=%h we=%b idx=%h d=%h cnt=%0d done=%b ovf=%b expected all zero",
                     O_OBJ_A, O_HIT_WE, O_HIT_IDX, O_HIT_D, O_HIT_CNT, O_DONE, O_OVF);
        end
        @(negedge clk);
        I_RST = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_all_miss;
        fill_bg(8'h00);
        run_scan(8'h40, -10, 0, -10, 8'h00, 400);
        checks++;
        if (done_k !== 193) begin failures++; $display("FAIL all_miss_done_cycle: got %0d expected 193", done_k); end
        checks++;
        if (nwe !== 0) begin failures++; $display("FAIL all_miss_we_count: got %0d expected 0", nwe); end
        checks++;
        if (fin_cnt !== 5'd0 || fin_ovf !== 1'b0) begin
            failures++; $display("FAIL all_miss_cnt_ovf: got cnt=%0d ovf=%b expected cnt=0 ovf=0", fin_cnt, fin_ovf);
        end
    endtask

    task automatic test_single_hit;
        fill_bg(8'h00);
        set_obj(5, 8'h40, 8'h12, 8'h03, 8'h80);
        run_scan(8'h45, -10, 0, -10, 8'h00, 400);
        checks++;
        if (nwe !== 1) begin failures++; $display("FAIL single_we_count: got %0d expected 1", nwe); end
        checks++;
        if (we_idx[0] !== 4'd0 || we_dat[0] !== 32'h8003_1205) begin
            failures++; $display("FAIL single_record: got idx=%0d d=%h expected idx=0 d=80031205", we_idx[0], we_dat[0]);
        end
        checks++;
        if (we_k[0] !== 15 || we_cnt[0] !== 5'd1) begin
            failures++; $display("FAIL single_we_timing: got cycle=%0d cnt=%0d expected cycle=15 cnt=1", we_k[0], we_cnt[0]);
        end
        checks++;
        if (done_k !== 196) begin failures++; $display("FAIL single_done_cycle: got %0d expected 196", done_k); end
        checks++;
        if (fin_cnt !== 5'd1 || fin_ovf !== 1'b0) begin
            failures++; $display("FAIL single_cnt_ovf: got cnt=%0d ovf=%b expected cnt=1 ovf=0", fin_cnt, fin_ovf);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] exp_d;
        fill_bg(8'h00);
        for (int n = 0; n < 20; n++) set_obj(n, 8'h10, 8'(n), 8'h00, 8'(32 + n));
        run_scan(8'h10, -10, 0, -10, 8'h00, 400);
        checks++;
        if (nwe !== 16) begin failures++; $display("FAIL ovf_we_count: got %0d expected 16", nwe); end
        for (int i = 0; i < 16; i++) begin
            exp_d = {8'(32 + i), 8'h00, 8'(i), 8'h00};
            checks++;
            if (we_idx[i] !== 4'(i) || we_dat[i] !== exp_d || we_k[i] !== 5 * i + 5) begin
                failures++;
                $display("FAIL ovf_record_%0d: got idx=%0d d=%h cycle=%0d expected idx=%0d d=%h cycle=%0d",
                         i, we_idx[i], we_dat[i], we_k[i], i, exp_d, 5 * i + 5);
            end
        end
        checks++;
        if (done_k !== 83) begin failures++; $display("FAIL ovf_done_cycle: got %0d expected 83", done_k); end
        checks++;
        if (fin_cnt !== 5'd16 || fin_ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_cnt_flag: got cnt=%0d ovf=%b expected cnt=16 ovf=1", fin_cnt, fin_ovf);
        end
        checks++;
        if (both_seen !== 0) begin failures++; $display("FAIL ovf_we_with_done: got %0d expected 0", both_seen); end
    endtask

    task automatic test_wrap;
        fill_bg(8'h80);
        set_obj(7, 8'hF8, 8'hAA, 8'hBB, 8'hCC);
        run_scan(8'h02, -10, 0, -10, 8'h00, 400);
        checks++;
        if (nwe !== 1 || we_dat[0] !== 32'hCCBB_AA0A) begin
            failures++; $display("FAIL wrap_hit: got count=%0d d=%h expected count=1 d=ccbbaa0a", nwe, we_dat[0]);
        end
        checks++;
        if (done_k !== 196) begin failures++; $display("FAIL wrap_hit_done: got %0d expected 196", done_k); end
        set_obj(7, 8'h02, 8'hAA, 8'hBB, 8'hCC);
        run_scan(8'hF8, -10, 0, -10, 8'h00, 400);
        checks++;
        if (nwe !== 0 || done_k !== 193 || fin_cnt !== 5'd0) begin
            failures++; $display("FAIL wrap_miss: got count=%0d done=%0d cnt=%0d expected 0 193 0", nwe, done_k, fin_cnt);
        end
    endtask

    task automatic test_hold;
        fill_bg(8'h00);
        set_obj(5, 8'h40, 8'h12, 8'h03, 8'h80);
        set_obj(50, 8'h3A, 8'h34, 8'h56, 8'h78);
        run_scan(8'h45, 12, 50, -10, 8'h00, 600);
        checks++;
        if (nwe !== 2) begin failures++; $display("FAIL hold_we_count: got %0d expected 2", nwe); end
        checks++;
        if (we_dat[0] !== 32'h8003_1205 || we_dat[1] !== 32'h7856_340B || we_idx[1] !== 4'd1) begin
            failures++; $display("FAIL hold_records: got %h %h idx1=%0d expected 80031205 7856340b idx1=1",
                                 we_dat[0], we_dat[1], we_idx[1]);
        end
        checks++;
        if (we_k[0] !== 65) begin failures++; $display("FAIL hold_we_delay: got %0d expected 65", we_k[0]); end
        checks++;
        if (done_k !== 249) begin failures++; $display("FAIL hold_done_cycle: got %0d expected 249", done_k); end
    endtask

    task automatic test_restart;
        fill_bg(8'h00);
        set_obj(5, 8'h40, 8'h12, 8'h03, 8'h80);
        set_obj(50, 8'h3A, 8'h34, 8'h56, 8'h78);
        run_scan(8'h45, -10, 0, 40, 8'h4A, 600);
        checks++;
        if (cnt_snap !== 5'd0) begin failures++; $display("FAIL restart_cnt_clear: got %0d expected 0", cnt_snap); end
        checks++;
        if (nwe !== 2 || we_dat[0] !== 32'h8003_1205 || we_dat[1] !== 32'h8003_120A || we_idx[1] !== 4'd0) begin
            failures++; $display("FAIL restart_records: got count=%0d %h %h idx1=%0d expected 2 80031205 8003120a 0",
                                 nwe, we_dat[0], we_dat[1], we_idx[1]);
        end
        checks++;
        if (done_k !== 237 || fin_cnt !== 5'd1) begin
            failures++; $display("FAIL restart_done: got cycle=%0d cnt=%0d expected 237 1", done_k, fin_cnt);
        end
    endtask

    task automatic test_reset_mid_scan;
        fill_bg(8'h00);
        set_obj(5, 8'h40, 8'h12, 8'h03, 8'h80);
        do_start(8'h45);
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (O_HIT_WE !== 1'b1 || O_HIT_CNT !== 5'd1) begin
            failures++; $display("FAIL rst_mid_precond: got we=%b cnt=%0d expected we=1 cnt=1", O_HIT_WE, O_HIT_CNT);
        end
        I_RST = 1'b1;
        #1;
        checks++;
        if ({O_OBJ_A, O_HIT_WE, O_HIT_IDX, O_HIT_D, O_HIT_CNT, O_DONE, O_OVF} !== 53'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got A=%h we=%b idx=%h d=%h cnt=%0d done=%b ovf=%b expected all zero",
                     O_OBJ_A, O_HIT_WE, O_HIT_IDX, O_HIT_D, O_HIT_CNT, O_DONE, O_OVF);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        I_RST = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        I_RST = 1'b1; I_SCAN_START = 1'b0; I_VPOS = 8'h00; I_HOLD = 1'b0;
        fill_bg(8'h00);
        test_reset;
        test_all_miss;
        test_single_hit;
        test_overflow;
        test_wrap;
        test_hold;
        test_restart;
        test_reset_mid_scan;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dkong3_obj_scan.md
Name: dkong3_obj_scan

Overview:
- Per-scanline sprite evaluator downstream of the sprite DMA. Reads the 96-entry object RAM that the DMA fills, 4 bytes per entry: Y, code, attr, X.
- For each scanline it finds the sprites that intersect the next line and writes them, in RAM order, into a 16-entry hit list for the line-buffer sprite drawer.
- Signals list complete and overflow.

Parameters:
- NUM_OBJ, 96: object entries scanned per line (0..NUM_OBJ-1).
- OBJ_BASE, 10'h000: object RAM address of entry 0. Entry n byte b is at OBJ_BASE + 4n + b.
- MAX_HITS, 16: hit list capacity.
- Y_OFS, 8'h00: added to I_VPOS before the compare, modulo 256.
- OBJ_H, 16: sprite height in lines.

Ports:
- I_CLK  in  1  system clock
- I_RST  in  1  asynchronous, active-high reset
- I_SCAN_START  in  1  rising edge starts a scan for line I_VPOS
- I_VPOS  in  8  next scanline number, sampled on the start edge
- I_HOLD  in  1  stall; high while DMA owns the object RAM
- O_OBJ_A  out  10  object RAM read address
- I_OBJ_D  in  8  object RAM read data, valid 1 cycle after O_OBJ_A
- O_HIT_WE  out  1  hit list write strobe, one cycle per hit
- O_HIT_IDX  out  4  hit list slot being written
- O_HIT_D  out  32  {X, attr, code, line-in-sprite[7:0]}
- O_HIT_CNT  out  5  number of valid hits this line
- O_DONE  out  1  one-cycle pulse at scan completion
- O_OVF  out  1  overflow flag for this line

Behaviour:
- Reset (async, I_RST high): state IDLE; all outputs 0; internal entry counter n = 0, hit count = 0, latched line = 0.
- Start detection: edge = I_SCAN_START high while its registered copy is low. The edge is accepted in any state, including mid-scan. On accept:
  - latch L = I_VPOS + Y_OFS (8-bit wrap)
  - n = 0, O_HIT_CNT = 0, O_OVF = 0
  - state FETCH_Y; any scan in progress is abandoned
- FETCH_Y:
  - O_OBJ_A = OBJ_BASE + 4n; next state EVAL.
- EVAL (I_OBJ_D = Y):
  - d = (L - Y) mod 256. Hit iff d < OBJ_H; latch d.
  - Miss: if n == NUM_OBJ-1 go to FIN, else n++ and go to FETCH_Y. A miss costs 2 cycles.
  - Hit with O_HIT_CNT == MAX_HITS: set O_OVF and go to FIN.
  - Other hit: drive O_OBJ_A = +1 and go to B1.
- B1: latch code; O_OBJ_A = +2.
- B2: latch attr; O_OBJ_A = +3.
- B3: latch X. On the next edge, register the hit-list write:
  - O_HIT_WE = 1, O_HIT_IDX = O_HIT_CNT[3:0], O_HIT_D assembled.
  - O_HIT_CNT increments in the same cycle WE is high.
  - Then advance n, or go to FIN if it is the last entry. A hit costs 5 cycles.
- FIN: O_DONE = 1 for exactly one cycle; go to IDLE. O_HIT_CNT and O_OVF hold until the next start.
- Worst-case latency from start edge to O_DONE:
  - all miss: 2*NUM_OBJ + 1 = 193 cycles
  - 16 hits: 193 + 48 cycles
- I_HOLD high: the FSM, counters, address and latches freeze, and O_HIT_WE / O_DONE are forced low. Resume on release; the same RAM address is re-read, so data stays correct.
- A start edge while I_HOLD is high is still latched, and takes effect when I_HOLD is released.
- O_HIT_WE is never high in the same cycle as O_DONE.
- Y wrap: Y = 8'hF8 and L = 8'h02 gives d = 10, which is a hit.
- An abandoned scan never raises O_DONE. Writes already issued to the list stay in the list, but O_HIT_CNT is reset to 0.

Decomposition:
- Shared package dkong3_obj_pkg holds:
  - object byte offsets (OFS_Y = 0, OFS_CODE = 1, OFS_ATTR = 2, OFS_X = 3)
  - the FSM state enum (IDLE, FETCH_Y, EVAL, B1, B2, B3, FIN)
  - the hit-record field positions
- One natural sub-module: dkong3_obj_ycmp, the combinational wrap-compare producing hit and d. Everything else stays in one module.

Test Plan:
- Cleared RAM (all Y = 0), I_VPOS = 8'h40 -> no WE, O_DONE exactly 193 cycles after the start edge, O_HIT_CNT = 0, O_OVF = 0.
- Entry 5 = {Y 40, code 12, attr 03, X 80}, I_VPOS = 8'h45 -> one WE, IDX 0, O_HIT_D = 32'h80031205, O_HIT_CNT = 1, O_DONE at 196 cycles.
- 20 entries all with Y = 8'h10, I_VPOS = 8'h10 -> 16 WEs at IDX 0..15 for entries 0..15, O_OVF = 1, O_DONE right after the 17th hit's EVAL.
- Wrap: Y = 8'hF8, I_VPOS = 8'h02 -> hit with d = 10. Y = 8'h02, I_VPOS = 8'hF8 -> miss.
- I_HOLD high for 50 cycles mid-scan -> identical hit list, and O_DONE delayed by exactly 50 cycles.
- Second start edge mid-scan -> O_HIT_CNT returns to 0, a single O_DONE, and results match a scan of the new line. Asserting I_RST mid-scan -> all outputs 0 immediately.
